// File: rtl/alarm_clock_multi_pkg.sv
// Shared constants and types for the multi-channel alarm clock core.
package clock_pkg;
  localparam int C_NS = 60;
  localparam int C_NH = 24;
  localparam int C_ND = 7;
  localparam int C_NA = 4;
  localparam int C_NR = 60;
  localparam int C_NZ = 300;
  localparam int C_W  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RING = 2'd1,
    SNZ  = 2'd2
  } ring_state_t;

  typedef logic [C_W-1:0] time_t;
endpackage

// File: rtl/alarm_clock_multi_if.sv
// Control/status bundle between the alarm clock core and its front panel.
interface alarm_clock_multi_if #(
  parameter int NA = 4,
  parameter int W  = 7,
  parameter int ND = 7
);
  localparam int AW = $clog2(NA);
  localparam int DW = $clog2(ND);

  logic          Timeset;
  logic          Alarmset;
  logic          Minadv;
  logic          Hrsadv;
  logic          Dayadv;
  logic          Alarmon;
  logic [NA-1:0] Aen;
  logic [AW-1:0] Asel;
  logic          Snooze;
  logic [W-1:0]  TSec;
  logic [W-1:0]  TMin;
  logic [W-1:0]  THrs;
  logic [DW-1:0] TDay;
  logic [W-1:0]  DMin;
  logic [W-1:0]  DHrs;
  logic          Buzz;
  logic [NA-1:0] Aact;

  modport master (
    output Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmon, Aen, Asel, Snooze,
    input  TSec, TMin, THrs, TDay, DMin, DHrs, Buzz, Aact
  );

  modport slave (
    input  Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmon, Aen, Asel, Snooze,
    output TSec, TMin, THrs, TDay, DMin, DHrs, Buzz, Aact
  );
endinterface

// File: rtl/alarm_clock_multi_alarm_chan.sv
// One alarm channel: minute/hour registers with non-carrying advance and a time match flag.
module alarm_chan #(
  parameter int NS = 60,
  parameter int NH = 24,
  parameter int W  = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_adv_min,
  input  logic         i_adv_hrs,
  input  logic [W-1:0] i_tmin,
  input  logic [W-1:0] i_thrs,
  output logic [W-1:0] o_amin,
  output logic [W-1:0] o_ahrs,
  output logic         o_match
);
  logic [W-1:0] r_amin;
  logic [W-1:0] r_ahrs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_amin <= '0;
      r_ahrs <= '0;
    end else begin
      if (i_adv_min) r_amin <= (r_amin == W'(NS-1)) ? '0 : r_amin + 1'b1;
      if (i_adv_hrs) r_ahrs <= (r_ahrs == W'(NH-1)) ? '0 : r_ahrs + 1'b1;
    end
  end

  assign o_amin  = r_amin;
  assign o_ahrs  = r_ahrs;
  assign o_match = (i_tmin == r_amin) && (i_thrs == r_ahrs);
endmodule

// File: rtl/alarm_clock_multi.sv
// Time-of-day/day-of-week clock with NA alarm channels, timed ring and optional snooze.
// Optional feature: define SNOOZE_EN to build the SNZ state and snooze counter.
module alarm_clock_multi
  import clock_pkg::*;
#(
  parameter int NS = C_NS,
  parameter int NH = C_NH,
  parameter int ND = C_ND,
  parameter int NA = C_NA,
  parameter int NR = C_NR,
  parameter int NZ = C_NZ,
  parameter int W  = C_W
) (
  input logic               Pulse,
  input logic               Reset,
  alarm_clock_multi_if.slave bus
);
  localparam int AW  = $clog2(NA);
  localparam int DW  = $clog2(ND);
  localparam int RCW = (NR > 1) ? $clog2(NR) : 1;

  logic [W-1:0]  r_sec, r_min, r_hrs;
  logic [DW-1:0] r_day;
  logic          w_sec_wrap, w_min_wrap, w_hrs_wrap, w_day_wrap, w_aset;

  assign w_sec_wrap = (r_sec == W'(NS-1));
  assign w_min_wrap = (r_min == W'(NS-1));
  assign w_hrs_wrap = (r_hrs == W'(NH-1));
  assign w_day_wrap = (r_day == DW'(ND-1));
  assign w_aset     = bus.Alarmset & ~bus.Timeset;

  always_ff @(posedge Pulse) begin
    if (Reset) begin
      r_sec <= '0;
      r_min <= '0;
      r_hrs <= '0;
      r_day <= '0;
    end else if (bus.Timeset) begin
      if (bus.Minadv) r_min <= w_min_wrap ? '0 : r_min + 1'b1;
      if (bus.Hrsadv) r_hrs <= w_hrs_wrap ? '0 : r_hrs + 1'b1;
      if (bus.Dayadv) r_day <= w_day_wrap ? '0 : r_day + 1'b1;
    end else begin
      r_sec <= w_sec_wrap ? '0 : r_sec + 1'b1;
      if (w_sec_wrap) begin
        r_min <= w_min_wrap ? '0 : r_min + 1'b1;
        if (w_min_wrap) begin
          r_hrs <= w_hrs_wrap ? '0 : r_hrs + 1'b1;
          if (w_hrs_wrap) r_day <= w_day_wrap ? '0 : r_day + 1'b1;
        end
      end
    end
  end

  logic [NA-1:0] w_match, w_trig, w_adv_min, w_adv_hrs;
  logic [W-1:0]  w_amin [NA];
  logic [W-1:0]  w_ahrs [NA];

  for (genvar i = 0; i < NA; i++) begin : g_chan
    assign w_adv_min[i] = w_aset & bus.Minadv & (bus.Asel == AW'(i));
    assign w_adv_hrs[i] = w_aset & bus.Hrsadv & (bus.Asel == AW'(i));
    alarm_chan #(.NS(NS), .NH(NH), .W(W)) u_chan (
      .clk      (Pulse),
      .rst      (Reset),
      .i_adv_min(w_adv_min[i]),
      .i_adv_hrs(w_adv_hrs[i]),
      .i_tmin   (r_min),
      .i_thrs   (r_hrs),
      .o_amin   (w_amin[i]),
      .o_ahrs   (w_ahrs[i]),
      .o_match  (w_match[i])
    );
    // Compare uses the pre-edge time, so ring starts one Pulse after hh:mm:00 appears
    assign w_trig[i] = bus.Aen[i] & bus.Alarmon & ~bus.Timeset & (r_sec == '0) & w_match[i];
  end

  ring_state_t    r_state, w_state_nxt;
  logic [RCW-1:0] r_rcnt, w_rcnt_nxt;
  logic [NA-1:0]  r_aact, w_aact_nxt;
  logic           r_buzz, w_buzz_nxt;
`ifdef SNOOZE_EN
  localparam int ZCW = (NZ > 1) ? $clog2(NZ) : 1;
  logic [ZCW-1:0] r_scnt, w_scnt_nxt;
`else
  logic w_unused_snooze;
  assign w_unused_snooze = bus.Snooze;
`endif

  always_ff @(posedge Pulse) begin
    if (Reset) begin
      r_state <= IDLE;
      r_rcnt  <= '0;
      r_aact  <= '0;
      r_buzz  <= 1'b0;
`ifdef SNOOZE_EN
      r_scnt  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_aact  <= w_aact_nxt;
      r_buzz  <= w_buzz_nxt;
`ifdef SNOOZE_EN
      r_scnt  <= w_scnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_aact_nxt  = r_aact;
`ifdef SNOOZE_EN
    w_scnt_nxt  = r_scnt;
`endif
    if (!bus.Alarmon) begin
      w_state_nxt = IDLE;
      w_rcnt_nxt  = '0;
      w_aact_nxt  = '0;
`ifdef SNOOZE_EN
      w_scnt_nxt  = '0;
`endif
    end else begin
      case (r_state)
        RING: begin
`ifdef SNOOZE_EN
          if (bus.Snooze) begin
            w_state_nxt = SNZ;
            w_scnt_nxt  = ZCW'(NZ-1);
          end else
`endif
          if (r_rcnt == RCW'(NR-1)) begin
            w_state_nxt = IDLE;
            w_rcnt_nxt  = '0;
            w_aact_nxt  = '0;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
            w_aact_nxt = r_aact | w_trig;
          end
        end
`ifdef SNOOZE_EN
        SNZ: begin
          if (|w_trig || r_scnt == '0) begin
            w_state_nxt = RING;
            w_rcnt_nxt  = '0;
            w_aact_nxt  = r_aact | w_trig;
          end else begin
            w_scnt_nxt = r_scnt - 1'b1;
          end
        end
`endif
        default: begin
          if (|w_trig) begin
            w_state_nxt = RING;
            w_rcnt_nxt  = '0;
            w_aact_nxt  = w_trig;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_buzz_nxt = (w_state_nxt == RING);
  end

  always_comb begin
    bus.DMin = r_min;
    bus.DHrs = r_hrs;
    if (w_aset) begin
      bus.DMin = w_amin[bus.Asel];
      bus.DHrs = w_ahrs[bus.Asel];
    end
  end

  assign bus.TSec = r_sec;
  assign bus.TMin = r_min;
  assign bus.THrs = r_hrs;
  assign bus.TDay = r_day;
  assign bus.Buzz = r_buzz;
  assign bus.Aact = r_aact;
endmodule

// File: tb/tb_alarm_clock_multi.sv
// Bench for alarm_clock_multi: vector table, directed ring/snooze sequences, random run vs reference model.
module tb_alarm_clock_multi;
  import clock_pkg::*;

  localparam int TOT = C_NS * C_NS * C_NH * C_ND;
`ifdef SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic Pulse = 1'b0;
  logic Reset = 1'b0;
  always #5 Pulse = ~Pulse;

  alarm_clock_multi_if #(.NA(C_NA), .W(C_W), .ND(C_ND)) bus ();

  alarm_clock_multi dut (
    .Pulse(Pulse),
    .Reset(Reset),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: time kept as seconds-of-week, ring/snooze as remaining Pulses
  int m_t;
  int m_amin [C_NA];
  int m_ahrs [C_NA];
  int m_ring, m_snz, m_aact;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [42:0] pack(input int s, input int m, input int h, input int d,
                                       input int dm, input int dh, input int b, input int a);
    return {7'(s), 7'(m), 7'(h), 3'(d), 7'(dm), 7'(dh), 1'(b), 4'(a)};
  endfunction

  task automatic model_step();
    int s, m, h, d, trig, a;
    s = m_t % C_NS;
    m = (m_t / C_NS) % C_NS;
    h = (m_t / (C_NS * C_NS)) % C_NH;
    d = m_t / (C_NS * C_NS * C_NH);
    trig = 0;
    for (int i = 0; i < C_NA; i++)
      if (bus.Aen[i] && bus.Alarmon && !bus.Timeset && s == 0 && m == m_amin[i] && h == m_ahrs[i])
        trig |= (1 << i);
    if (Reset) begin
      m_t = 0; m_ring = 0; m_snz = 0; m_aact = 0;
      for (int i = 0; i < C_NA; i++) begin m_amin[i] = 0; m_ahrs[i] = 0; end
      return;
    end
    if (!bus.Alarmon) begin
      m_ring = 0; m_snz = 0; m_aact = 0;
    end else if (m_ring > 0) begin
      if (SNZ_EN && bus.Snooze) begin
        m_snz = C_NZ; m_ring = 0;
      end else begin
        m_ring--;
        if (m_ring == 0) m_aact = 0;
        else m_aact |= trig;
      end
    end else if (m_snz > 0) begin
      if (trig != 0) begin
        m_ring = C_NR; m_snz = 0; m_aact |= trig;
      end else begin
        m_snz--;
        if (m_snz == 0) m_ring = C_NR;
      end
    end else if (trig != 0) begin
      m_ring = C_NR; m_aact = trig;
    end
    if (bus.Alarmset && !bus.Timeset) begin
      a = int'(bus.Asel);
      if (bus.Minadv) m_amin[a] = (m_amin[a] + 1) % C_NS;
      if (bus.Hrsadv) m_ahrs[a] = (m_ahrs[a] + 1) % C_NH;
    end
    if (bus.Timeset) begin
      if (bus.Minadv) m = (m + 1) % C_NS;
      if (bus.Hrsadv) h = (h + 1) % C_NH;
      if (bus.Dayadv) d = (d + 1) % C_ND;
      m_t = ((d * C_NH + h) * C_NS + m) * C_NS + s;
    end else begin
      m_t = (m_t + 1) % TOT;
    end
  endtask

  task automatic pulse();
    int s, m, h, d, dm, dh;
    model_step();
    @(posedge Pulse);
    #1;
    s = m_t % C_NS;
    m = (m_t / C_NS) % C_NS;
    h = (m_t / (C_NS * C_NS)) % C_NH;
    d = m_t / (C_NS * C_NS * C_NH);
    dm = m; dh = h;
    if (bus.Alarmset && !bus.Timeset) begin
      dm = m_amin[int'(bus.Asel)];
      dh = m_ahrs[int'(bus.Asel)];
    end
    chk("model", pack(bus.TSec, bus.TMin, bus.THrs, bus.TDay, bus.DMin, bus.DHrs, bus.Buzz, bus.Aact),
        pack(s, m, h, d, dm, dh, (m_ring > 0) ? 1 : 0, m_aact));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  task automatic drive(input bit ts, input bit as, input bit ma, input bit ha, input bit da,
                       input bit aon, input bit [3:0] aen, input bit [1:0] asel, input bit snz);
    bus.Timeset  = ts;
    bus.Alarmset = as;
    bus.Minadv   = ma;
    bus.Hrsadv   = ha;
    bus.Dayadv   = da;
    bus.Alarmon  = aon;
    bus.Aen      = aen;
    bus.Asel     = asel;
    bus.Snooze   = snz;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    pulse();
    Reset = 1'b0;
  endtask

  typedef struct {
    bit ts, as, ma, ha, da, aon;
    bit [3:0] aen;
    bit [1:0] asel;
    int n;
    int sec, min, hrs, day, dmin, dhrs;
    bit buzz;
    bit [3:0] aact;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ts as ma ha da aon aen   asel n    sec min hrs day dmin dhrs buzz aact
    tbl[0]  = '{1, 0, 0, 1, 0, 0, 4'h0, 2'd0, 23,  0,  0,  23, 0,  0,  23,  0, 4'h0};
    tbl[1]  = '{1, 0, 1, 0, 0, 0, 4'h0, 2'd0, 59,  0,  59, 23, 0,  59, 23,  0, 4'h0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 4'h0, 2'd0, 60,  0,  0,  0,  1,  0,  0,   0, 4'h0};
    tbl[3]  = '{1, 0, 1, 0, 0, 0, 4'h0, 2'd0, 61,  0,  1,  0,  1,  1,  0,   0, 4'h0};
    tbl[4]  = '{1, 1, 1, 0, 0, 0, 4'h0, 2'd2, 1,   0,  2,  0,  1,  2,  0,   0, 4'h0};
    tbl[5]  = '{0, 1, 0, 0, 0, 0, 4'h0, 2'd2, 1,   1,  2,  0,  1,  0,  0,   0, 4'h0};
    tbl[6]  = '{0, 1, 0, 1, 0, 0, 4'h0, 2'd2, 7,   8,  2,  0,  1,  0,  7,   0, 4'h0};
    tbl[7]  = '{0, 1, 1, 0, 0, 0, 4'h0, 2'd2, 30,  38, 2,  0,  1,  30, 7,   0, 4'h0};
    tbl[8]  = '{1, 0, 0, 1, 0, 0, 4'h0, 2'd0, 7,   38, 2,  7,  1,  2,  7,   0, 4'h0};
    tbl[9]  = '{1, 0, 1, 0, 0, 0, 4'h0, 2'd0, 27,  38, 29, 7,  1,  29, 7,   0, 4'h0};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 4'h4, 2'd0, 21,  59, 29, 7,  1,  29, 7,   0, 4'h0};
    tbl[11] = '{0, 0, 0, 0, 0, 1, 4'h4, 2'd0, 1,   0,  30, 7,  1,  30, 7,   0, 4'h0};
    tbl[12] = '{0, 0, 0, 0, 0, 1, 4'h4, 2'd0, 1,   1,  30, 7,  1,  30, 7,   1, 4'h4};
    tbl[13] = '{0, 0, 0, 0, 0, 1, 4'h4, 2'd0, 59,  0,  31, 7,  1,  31, 7,   1, 4'h4};
    tbl[14] = '{0, 0, 0, 0, 0, 1, 4'h4, 2'd0, 1,   1,  31, 7,  1,  31, 7,   0, 4'h0};

    drive(0, 0, 0, 0, 0, 0, 4'h0, 2'd0, 0);
    do_reset();
    chk("reset", pack(bus.TSec, bus.TMin, bus.THrs, bus.TDay, bus.DMin, bus.DHrs, bus.Buzz, bus.Aact),
        pack(0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].ts, tbl[i].as, tbl[i].ma, tbl[i].ha, tbl[i].da, tbl[i].aon, tbl[i].aen, tbl[i].asel, 1'b0);
      run(tbl[i].n);
      chk($sformatf("vec%0d", i),
          pack(bus.TSec, bus.TMin, bus.THrs, bus.TDay, bus.DMin, bus.DHrs, bus.Buzz, bus.Aact),
          pack(tbl[i].sec, tbl[i].min, tbl[i].hrs, tbl[i].day, tbl[i].dmin, tbl[i].dhrs, tbl[i].buzz, tbl[i].aact));
    end

    // Second ring of channel 2, then snooze behaviour
    drive(1, 0, 1, 0, 0, 1, 4'h4, 2'd0, 0); run(58);
    drive(0, 0, 0, 0, 0, 1, 4'h4, 2'd0, 0); run(59);
    chk("ring2_pre", bus.Buzz, 1'b0);
    run(1);
    chk("ring2_rise", bus.Buzz, 1'b1);
    run(4);
    drive(0, 0, 0, 0, 0, 1, 4'h4, 2'd0, 1); run(1);
`ifdef SNOOZE_EN
    chk("snz_fall", bus.Buzz, 1'b0);
    chk("snz_aact", bus.Aact, 4'h4);
    drive(0, 0, 0, 0, 0, 1, 4'h4, 2'd0, 0); run(C_NZ - 1);
    chk("snz_wait", bus.Buzz, 1'b0);
    run(1);
    chk("snz_rerise", bus.Buzz, 1'b1);
    chk("snz_rerise_aact", bus.Aact, 4'h4);
    drive(0, 0, 0, 0, 0, 1, 4'h4, 2'd0, 1); run(1);
    chk("snz2_fall", bus.Buzz, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 4'h4, 2'd0, 0); run(1);
    chk("snz_off_aact", bus.Aact, 4'h0);
    drive(0, 0, 0, 0, 0, 1, 4'h4, 2'd0, 0); run(C_NZ + 5);
    chk("snz_cancel", bus.Buzz, 1'b0);
`else
    chk("snz_ignored", bus.Buzz, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 4'h4, 2'd0, 0); run(1);
    chk("alarmon_off", bus.Buzz, 1'b0);
    chk("alarmon_off_aact", bus.Aact, 4'h0);
`endif

    // Multi-channel: ch0 and ch3 both at 06:00
    drive(0, 0, 0, 0, 0, 0, 4'h0, 2'd0, 0);
    do_reset();
    drive(0, 1, 0, 1, 0, 0, 4'h0, 2'd0, 0); run(6);
    drive(0, 1, 0, 1, 0, 0, 4'h0, 2'd3, 0); run(6);
    drive(1, 0, 0, 1, 0, 0, 4'h0, 2'd0, 0); run(5);
    drive(1, 0, 1, 0, 0, 0, 4'h0, 2'd0, 0); run(59);
    drive(0, 0, 0, 0, 0, 1, 4'h9, 2'd0, 0); run(47);
    chk("multi_pre", bus.Buzz, 1'b0);
    run(1);
    chk("multi_0600", pack(bus.TSec, bus.TMin, bus.THrs, 0, 0, 0, bus.Buzz, 0), pack(0, 0, 6, 0, 0, 0, 0, 0));
    run(1);
    chk("multi_buzz", bus.Buzz, 1'b1);
    chk("multi_aact", bus.Aact, 4'h9);
    drive(0, 0, 0, 0, 0, 0, 4'h9, 2'd0, 0); run(1);
    drive(1, 0, 0, 1, 0, 0, 4'h9, 2'd0, 0); run(23);
    drive(1, 0, 1, 0, 0, 0, 4'h9, 2'd0, 0); run(59);
    drive(0, 0, 0, 0, 0, 1, 4'h9, 2'd0, 0); run(58);
    chk("ts_0600", pack(bus.TSec, bus.TMin, bus.THrs, 0, 0, 0, bus.Buzz, 0), pack(0, 0, 6, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 0, 1, 4'h9, 2'd0, 0); run(2);
    chk("ts_mask", bus.Buzz, 1'b0);
    chk("ts_mask_aact", bus.Aact, 4'h0);
    drive(0, 0, 0, 0, 0, 0, 4'h9, 2'd0, 0); run(1);

    // Post-reset trigger at 00:00:00 and reset mid-ring
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 4'h1, 2'd0, 0); run(1);
    chk("post_reset_trig", bus.Buzz, 1'b1);
    chk("post_reset_aact", bus.Aact, 4'h1);
    run(3);
    do_reset();
    chk("reset_mid_ring", bus.Buzz, 1'b0);
    chk("reset_mid_ring_aact", bus.Aact, 4'h0);
    drive(0, 0, 0, 0, 0, 0, 4'h0, 2'd0, 0); run(1);

    // Random inputs against the model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
            4'($urandom), 2'($urandom), $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) Reset = 1'b1;
      pulse();
      Reset = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alarm_clock_multi.md
# alarm_clock_multi

Parametrised time-of-day clock with day-of-week counter, NA independently programmable alarm channels, auto-timeout ring and snooze. It is the next-generation core behind the lab clock top level. It drives binary time and display values into the existing 2-digit 7-segment display drivers, and a registered buzzer. All state advances on the 1-per-second Pulse clock.

## Interface
- NS, 60: seconds/minutes modulus.
- NH, 24: hours modulus.
- ND, 7: days modulus.
- NA, 4: alarm channels (≥2).
- NR, 60: ring length in Pulses before auto-off.
- NZ, 300: snooze length in Pulses.
- W, 7: time field width (NS, NH ≤ 2^W).
- Pulse  in  1  clock, one edge per second.
- Reset  in  1  synchronous, active-high.
- Timeset  in  1  time-set mode, holds seconds.
- Alarmset  in  1  alarm-set mode.
- Minadv, Hrsadv, Dayadv  in  1 each  advance buttons, level, one step per Pulse.
- Alarmon  in  1  global alarm enable.
- Aen  in  NA  per-channel enable.
- Asel  in  $clog2(NA)  channel selected for set/display.
- Snooze  in  1  snooze request, level.
- TSec, TMin, THrs  out  W  current time.
- TDay  out  $clog2(ND)  day of week.
- DMin, DHrs  out  W  display values.
- Buzz  out  1  registered ring output.
- Aact  out  NA  channels that caused the current ring.

## Operation
- Reset: TSec/TMin/THrs/TDay = 0, all alarm min/hrs = 0, Buzz = 0, Aact = 0, ring and snooze counters = 0.
- Run mode (Timeset=0):
  - TSec increments every Pulse and wraps NS-1→0.
  - TMin increments when TSec wraps; THrs when TSec and TMin wrap together; TDay when all three wrap together (mod ND).
  - Dayadv is ignored in run mode.
- Time set (Timeset=1):
  - TSec holds.
  - Minadv steps TMin (mod NS), Hrsadv steps THrs (mod NH), Dayadv steps TDay. None of these carry into the next field.
  - Any combination may be active in the same Pulse.
- Alarm set (Alarmset=1, Timeset=0): Minadv/Hrsadv step the minute/hour registers of channel Asel only, with no carry. Timeset has priority, so with both asserted the alarm registers hold.
- Display: DMin/DHrs = alarm[Asel] when Alarmset & !Timeset, otherwise TMin/THrs. This path is combinational.
- Trigger: channel i fires when Aen[i] & Alarmon & !Timeset & TSec==0 & TMin==AMin[i] & THrs==AHrs[i]. Compare uses pre-edge register values.
- Ring FSM, states IDLE, RING, SNZ, evaluated in this priority order each Pulse:
  1. Alarmon=0: go to IDLE, Buzz=0, Aact=0, counters cleared.
  2. RING:
     - Snooze=1: go to SNZ, snooze counter = NZ-1, Buzz=0, Aact held.
     - Ring counter == NR-1: go to IDLE, Aact=0.
     - Otherwise: ring counter +1.
  3. SNZ:
     - Counter == 0: go to RING, ring counter = 0.
     - Otherwise: counter −1.
     - A new trigger in SNZ goes to RING immediately and ORs into Aact.
  4. IDLE with any trigger: go to RING, ring counter = 0, Aact = trigger vector.
- In RING, a further trigger ORs into Aact and does not restart the ring counter.
- Buzz = (state == RING).

## Timing
- Buzz rises on the Pulse edge after the one where TSec becomes 0 in the matching minute. That is one Pulse of latency from the display showing hh:mm:00.
- A ring lasts exactly NR Pulses if untouched.
- Snooze is sampled once per Pulse, so a single-Pulse assertion suffices. Buzz falls on that edge.
- Buzz re-rises exactly NZ Pulses after the snooze edge.
- Reset mid-ring or mid-snooze returns to IDLE on the same edge.
- Post-reset state of 00:00:00 with all alarms at 00:00 triggers on the first Pulse if Alarmon & Aen. This is intended.

## Configuration
- SNOOZE_EN defined: SNZ state, snooze counter and Snooze handling are present as above.
- SNOOZE_EN undefined: the Snooze port exists but is ignored, there is no SNZ state or counter, and RING is left only by timeout or Alarmon=0.

## Structure
- Package clock_pkg:
  - Default NS/NH/ND/NA/NR/NZ/W constants.
  - Ring state enum (IDLE, RING, SNZ).
  - Typedef for the W-bit time field.
- Sub-module alarm_chan, instantiated NA times:
  - Holds AMin/AHrs with synchronous reset.
  - Takes an advance strobe qualified by Asel.
  - Outputs its registers and the match bit.
- The top level holds the time counters, ring FSM and display mux.

## Test plan
- Rollover: reset, set 23:59 via Timeset + Minadv/Hrsadv, release, run 60 Pulses → TSec=0, TMin=0, THrs=0, TDay=1.
- Set-mode isolation: Timeset=1, Minadv held 61 Pulses from 0 → TMin=1, THrs unchanged, TSec unchanged.
- Trigger latency: alarm ch2 = 07:30, Aen=4'b0100, time 07:29:59, Alarmon=1 → Buzz=1 and Aact=4'b0100 two Pulses later; Buzz=0 after NR=60 further Pulses.
- Snooze (SNOOZE_EN): while ringing assert Snooze for 1 Pulse → Buzz=0 next edge, Buzz=1 exactly 300 Pulses later; Alarmon=0 during SNZ → no re-ring.
- Multi-channel: ch0 and ch3 both 06:00 → Aact=4'b1001; Timeset=1 at 06:00:00 → no trigger.
- Priority: Timeset=Alarmset=1 with Minadv → TMin steps, alarm[Asel] unchanged; DMin shows TMin.
